// File: rtl/second_loop_pkg.sv
// rtl/second_loop_pkg.sv - shared RC4 stage types and sizing constants
package second_loop_pkg;

  // S-box depth and key length in bytes, shared by init, key-schedule and decrypt stages
  localparam int N       = 256;
  localparam int KEY_LEN = 3;

  // Key-schedule loop states; each i takes exactly one pass ADDR_I..NEXT (9 states)
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_I  = 4'd1,
    WAIT_I  = 4'd2,
    READ_I  = 4'd3,
    ADDR_J  = 4'd4,
    WAIT_J  = 4'd5,
    READ_J  = 4'd6,
    WRITE_I = 4'd7,
    WRITE_J = 4'd8,
    NEXT    = 4'd9,
    DONE    = 4'd10
  } state_t;

endpackage

// File: rtl/second_loop.sv
// rtl/second_loop.sv - RC4 key-scheduling loop driving an external S-box RAM
module second_loop
  import second_loop_pkg::*;
#(
  parameter int KEY_LEN = second_loop_pkg::KEY_LEN,
  parameter int N       = second_loop_pkg::N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_flag,
  input  logic [8*KEY_LEN-1:0] secret_key,
  input  logic [7:0]           q,
  output logic [7:0]           address,
  output logic [7:0]           data,
  output logic                 wren,
  output logic                 done_flag
);

  // Key index counter width; a 1-byte key still gets a 1-bit counter
  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  state_t          state;
  state_t          next_state;
  logic [7:0]      i;
  logic [7:0]      j;
  logic [7:0]      si;
  logic [7:0]      sj;
  logic [KW-1:0]   key_idx;
  logic [7:0]      key_byte;
  logic            last_i;

  assign last_i = (i == 8'(N - 1));

  // Select key byte key_idx; byte 0 sits in the most significant position
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (key_idx == KW'(k)) begin
        key_byte = secret_key[8*(KEY_LEN-1-k) +: 8];
      end
    end
  end

  // State register; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing; start_flag only matters in IDLE and DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_flag) next_state = ADDR_I;
      ADDR_I:  next_state = WAIT_I;
      WAIT_I:  next_state = READ_I;
      READ_I:  next_state = ADDR_J;
      ADDR_J:  next_state = WAIT_J;
      WAIT_J:  next_state = READ_J;
      READ_J:  next_state = WRITE_I;
      WRITE_I: next_state = WRITE_J;
      WRITE_J: next_state = NEXT;
      NEXT:    next_state = last_i ? DONE : ADDR_I;
      DONE:    if (!start_flag) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered RAM port; the RAM returns q two clocks after address is loaded
  always_ff @(posedge clk) begin
    if (reset) begin
      address   <= '0;
      data      <= '0;
      wren      <= 1'b0;
      done_flag <= 1'b0;
      i         <= '0;
      j         <= '0;
      key_idx   <= '0;
      si        <= '0;
      sj        <= '0;
    end else begin
      case (state)
        IDLE: begin
          wren <= 1'b0;
          if (start_flag) begin
            i       <= '0;
            j       <= '0;
            key_idx <= '0;
          end
        end
        ADDR_I: begin
          address <= i;
          wren    <= 1'b0;
        end
        READ_I: begin
          si <= q;
          j  <= j + q + key_byte;
        end
        ADDR_J: begin
          address <= j;
        end
        READ_J: begin
          sj <= q;
        end
        WRITE_I: begin
          address <= i;
          data    <= sj;
          wren    <= 1'b1;
        end
        WRITE_J: begin
          address <= j;
          data    <= si;
          wren    <= 1'b1;
        end
        NEXT: begin
          wren <= 1'b0;
          if (last_i) begin
            done_flag <= 1'b1;
          end else begin
            i       <= i + 8'd1;
            key_idx <= (key_idx == KW'(KEY_LEN - 1)) ? '0 : key_idx + 1'b1;
          end
        end
        DONE: begin
          wren <= 1'b0;
          if (!start_flag) done_flag <= 1'b0;
        end
        default: begin
          wren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_second_loop.sv
// tb/tb_second_loop.sv - directed bench for the RC4 key-scheduling loop
module tb_second_loop;
  import second_loop_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_flag = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        done_flag;

  always #5 clk = ~clk;

  second_loop dut (
    .clk        (clk),
    .reset      (reset),
    .start_flag (start_flag),
    .secret_key (secret_key),
    .q          (q),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .done_flag  (done_flag)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // S-box RAM: registered read, so q reflects address two edges after the DUT loads it
  logic [7:0] mem [256];
  logic       ram_init = 1'b0;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else begin
      q <= mem[address];
      if (wren) mem[address] <= data;
    end
  end

  // Write log and wren run-length watch
  logic [15:0] wlog[$];
  int          wr_run = 0;
  always @(negedge clk) begin
    if (wren) begin
      wr_run++;
      wlog.push_back({address, data});
      check("wren_run_le2", 32'(wr_run > 2), 0);
    end else begin
      wr_run = 0;
    end
  end

  // Address must not move while a write is presented
  always @(negedge clk) begin
    logic [7:0] a;
    if (wren) begin
      a = address;
      #4;
      check("addr_stable", address, a);
    end
  end

  // Reference KSA
  logic [7:0] sw [256];
  task automatic soft_ksa(input logic [23:0] key);
    logic [7:0] jj, t, kb;
    jj = 0;
    for (int k = 0; k < 256; k++) sw[k] = 8'(k);
    for (int k = 0; k < 256; k++) begin
      case (k % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      jj = jj + sw[k] + kb;
      t = sw[k];
      sw[k] = sw[jj];
      sw[jj] = t;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start_flag = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic init_ram();
    @(negedge clk);
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
  endtask

  typedef struct {
    logic [23:0] key;
    int          pulse_at;
    logic [63:0] w;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc;
    int found;
    int mism;

    vecs[0] = '{key: 24'h010203, pulse_at: 0,   w: 64'h0001_0100_0103_0300};
    vecs[1] = '{key: 24'h000000, pulse_at: 0,   w: 64'h0000_0000_0101_0101};
    vecs[2] = '{key: 24'h050000, pulse_at: 0,   w: 64'h0005_0500_0106_0601};
    vecs[3] = '{key: 24'hFFFFFF, pulse_at: 0,   w: 64'h00FF_FF00_0100_FF01};
    vecs[4] = '{key: 24'h000249, pulse_at: 100, w: 64'h0000_0000_0103_0301};

    // Reset state and idling without start
    do_reset();
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_address", address, 0);
    check("rst_data", data, 0);
    check("rst_wren", wren, 0);
    check("rst_done", done_flag, 0);
    repeat (4) @(negedge clk);
    check("idle_hold", 32'(dut.state), 32'(IDLE));

    // Reset while in READ_J
    init_ram();
    secret_key = 24'h010203;
    start_flag = 1'b1;
    cyc = 0;
    found = 0;
    while (cyc < 20 && !found) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (dut.state == READ_J) found = 1;
    end
    check("reach_read_j", found, 1);
    check("read_j_cycle", cyc, 6);
    check("read_j_wren", wren, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rj_rst_state", 32'(dut.state), 32'(IDLE));
    check("rj_rst_address", address, 0);
    check("rj_rst_wren", wren, 0);
    check("rj_rst_done", done_flag, 0);
    @(negedge clk);
    reset = 1'b0;
    start_flag = 1'b0;

    // Reset while a write is presented
    init_ram();
    start_flag = 1'b1;
    cyc = 0;
    found = 0;
    while (cyc < 20 && !found) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (wren === 1'b1) found = 1;
    end
    check("reach_write", found, 1);
    check("write_cycle", cyc, 8);
    check("write_addr", address, 0);
    check("write_data", data, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("wr_rst_wren", wren, 0);
    check("wr_rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    start_flag = 1'b0;

    // Full key schedules
    for (int v = 0; v < 5; v++) begin
      do_reset();
      init_ram();
      wlog.delete();
      secret_key = vecs[v].key;
      start_flag = 1'b1;
      cyc = 0;
      while (cyc < 3000) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (done_flag === 1'b1) break;
        start_flag = (cyc == vecs[v].pulse_at) ? 1'b0 : 1'b1;
      end
      check($sformatf("done_cycle[%0d]", v), cyc, 2305);
      check($sformatf("done_state[%0d]", v), 32'(dut.state), 32'(DONE));
      check($sformatf("done_wren[%0d]", v), wren, 0);
      if (wlog.size() < 4) begin
        check($sformatf("wlog_size[%0d]", v), wlog.size(), 4);
      end else begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("write%0d[%0d]", k, v), wlog[k], vecs[v].w[63-16*k -: 16]);
        end
      end
      check($sformatf("write_count[%0d]", v), wlog.size(), 512);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("done_hold[%0d]", v), done_flag, 1);
      soft_ksa(vecs[v].key);
      mism = 0;
      for (int k = 0; k < 256; k++) begin
        if (mem[k] !== sw[k]) mism++;
      end
      check($sformatf("ram_mismatches[%0d]", v), mism, 0);
      start_flag = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("done_clear[%0d]", v), done_flag, 0);
      check($sformatf("back_idle[%0d]", v), 32'(dut.state), 32'(IDLE));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
